// File: rtl/fb_rect_filler.sv
// Rectangle-fill engine: walks a rectangle in raster order, one framebuffer write per cell.
// Optional macro FB_RECT_FILLER_CLIP_EN clamps out-of-range corners instead of rejecting.
module fb_rect_filler #(
    parameter int FB_W = 128,
    parameter int FB_H = 64,
    parameter int XW   = 8,
    parameter int YW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x0,
    input  logic [YW-1:0] cmd_y0,
    input  logic [XW-1:0] cmd_x1,
    input  logic [YW-1:0] cmd_y1,
    input  logic [1:0]    cmd_mode,
    input  logic [7:0]    cmd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          fb_we,
    output logic [XW-1:0] fb_w_xpos,
    output logic [YW-1:0] fb_w_ypos,
    output logic [7:0]    fb_din,
    input  logic          fb_w_data_valid
);

    // Index is at least 8 bits so the ramp mode can always take index[7:0].
    localparam int IW_RAW = $clog2(FB_W * FB_H);
    localparam int IW     = (IW_RAW > 8) ? IW_RAW : 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ISSUE,
        S_WAIT_ACK,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_cmd_ready;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_fb_we;
    logic [XW-1:0] r_fb_x;
    logic [YW-1:0] r_fb_y;
    logic [7:0]    r_fb_din;

    logic [XW-1:0] r_x0, r_x1, r_xl, r_xh, r_cur_x;
    logic [YW-1:0] r_y0, r_y1, r_yl, r_yh, r_cur_y;
    logic [1:0]    r_mode;
    logic [7:0]    r_data;
    logic [IW-1:0] r_index;

    logic [XW-1:0] w_xl, w_xh, w_xl_n, w_xh_n;
    logic [YW-1:0] w_yl, w_yh, w_yl_n, w_yh_n;
    logic          w_oob;
    logic          w_last;
    logic [7:0]    w_din;

    assign w_xl = (r_x0 < r_x1) ? r_x0 : r_x1;
    assign w_xh = (r_x0 < r_x1) ? r_x1 : r_x0;
    assign w_yl = (r_y0 < r_y1) ? r_y0 : r_y1;
    assign w_yh = (r_y0 < r_y1) ? r_y1 : r_y0;

`ifdef FB_RECT_FILLER_CLIP_EN
    assign w_xl_n = (32'(w_xl) >= FB_W) ? XW'(FB_W - 1) : w_xl;
    assign w_xh_n = (32'(w_xh) >= FB_W) ? XW'(FB_W - 1) : w_xh;
    assign w_yl_n = (32'(w_yl) >= FB_H) ? YW'(FB_H - 1) : w_yl;
    assign w_yh_n = (32'(w_yh) >= FB_H) ? YW'(FB_H - 1) : w_yh;
    assign w_oob  = 1'b0;
`else
    assign w_xl_n = w_xl;
    assign w_xh_n = w_xh;
    assign w_yl_n = w_yl;
    assign w_yh_n = w_yh;
    // The max corner covers both corners of each axis.
    assign w_oob  = (32'(w_xh) >= FB_W) || (32'(w_yh) >= FB_H);
`endif

    assign w_last = (r_cur_x == r_xh) && (r_cur_y == r_yh);

    always_comb begin
        w_din = r_data;
        case (r_mode)
            2'd0:    w_din = r_data;
            2'd1:    w_din = 8'h00;
            2'd2:    w_din = (r_cur_x[0] ^ r_cur_y[0]) ? ~r_data : r_data;
            default: w_din = r_data + r_index[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_fb_we     <= 1'b0;
            r_fb_x      <= '0;
            r_fb_y      <= '0;
            r_fb_din    <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_y0        <= '0;
            r_y1        <= '0;
            r_xl        <= '0;
            r_xh        <= '0;
            r_yl        <= '0;
            r_yh        <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_mode      <= '0;
            r_data      <= '0;
            r_index     <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_x0        <= cmd_x0;
                        r_x1        <= cmd_x1;
                        r_y0        <= cmd_y0;
                        r_y1        <= cmd_y1;
                        r_mode      <= cmd_mode;
                        r_data      <= cmd_data;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_LATCH;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (w_oob) begin
                        r_err       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_xl    <= w_xl_n;
                        r_xh    <= w_xh_n;
                        r_yl    <= w_yl_n;
                        r_yh    <= w_yh_n;
                        r_cur_x <= w_xl_n;
                        r_cur_y <= w_yl_n;
                        r_index <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_fb_we  <= 1'b1;
                    r_fb_x   <= r_cur_x;
                    r_fb_y   <= r_cur_y;
                    r_fb_din <= w_din;
                    r_state  <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (fb_w_data_valid) begin
                        r_fb_we <= 1'b0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Ack must drop before the next write, guaranteeing an fb_we-low gap.
                    if (!fb_w_data_valid) begin
                        r_index <= r_index + 1'b1;
                        if (r_cur_x == r_xh) begin
                            r_cur_x <= r_xl;
                            r_cur_y <= r_cur_y + 1'b1;
                        end else begin
                            r_cur_x <= r_cur_x + 1'b1;
                        end
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign fb_we     = r_fb_we;
    assign fb_w_xpos = r_fb_x;
    assign fb_w_ypos = r_fb_y;
    assign fb_din    = r_fb_din;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Directed bench for fb_rect_filler: framebuffer responder model plus write scoreboard.
// Honours FB_RECT_FILLER_CLIP_EN for the out-of-range expectations.
module tb_fb_rect_filler;

    localparam int FB_W = 128;
    localparam int FB_H = 64;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] d;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_data;
    logic       busy, done, err;
    logic       fb_we;
    logic [7:0] fb_w_xpos, fb_w_ypos, fb_din;
    logic       fb_w_data_valid;

    wr_t sb[$];
    int  n_pass = 0;
    int  n_chk = 0;
    int  n_done = 0;
    int  n_err = 0;
    int  n_busy = 0;
    int  n_writes = 0;
    int  ack_delay = 0;
    int  wcnt = 0;
    wr_t cap;

    fb_rect_filler #(
        .FB_W(FB_W),
        .FB_H(FB_H),
        .XW  (8),
        .YW  (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_x0         (cmd_x0),
        .cmd_y0         (cmd_y0),
        .cmd_x1         (cmd_x1),
        .cmd_y1         (cmd_y1),
        .cmd_mode       (cmd_mode),
        .cmd_data       (cmd_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .fb_we          (fb_we),
        .fb_w_xpos      (fb_w_xpos),
        .fb_w_ypos      (fb_w_ypos),
        .fb_din         (fb_din),
        .fb_w_data_valid(fb_w_data_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Framebuffer responder: acks after ack_delay stalled cycles, drops ack once fb_we falls.
    initial begin
        fb_w_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fb_w_data_valid = 1'b0;
                wcnt = 0;
            end else if (fb_we && !fb_w_data_valid) begin
                if (wcnt == 0) begin
                    cap.x = fb_w_xpos;
                    cap.y = fb_w_ypos;
                    cap.d = fb_din;
                    n_writes++;
                end else begin
                    check("stable_x", {24'd0, fb_w_xpos}, {24'd0, cap.x});
                    check("stable_y", {24'd0, fb_w_ypos}, {24'd0, cap.y});
                    check("stable_d", {24'd0, fb_din}, {24'd0, cap.d});
                end
                if (wcnt >= ack_delay) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write", {31'd0, fb_we}, 32'd0);
                    end else begin
                        wr_t e;
                        e = sb.pop_front();
                        check("wr_x", {24'd0, fb_w_xpos}, {24'd0, e.x});
                        check("wr_y", {24'd0, fb_w_ypos}, {24'd0, e.y});
                        check("wr_d", {24'd0, fb_din}, {24'd0, e.d});
                    end
                    fb_w_data_valid = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else if (!fb_we && fb_w_data_valid) begin
                fb_w_data_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (err) n_err++;
            if (busy) n_busy++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input int mode, input logic [7:0] data);
        int xl, xh, yl, yh, idx;
        wr_t e;
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
`ifdef FB_RECT_FILLER_CLIP_EN
        if (xl > FB_W - 1) xl = FB_W - 1;
        if (xh > FB_W - 1) xh = FB_W - 1;
        if (yl > FB_H - 1) yl = FB_H - 1;
        if (yh > FB_H - 1) yh = FB_H - 1;
`endif
        idx = 0;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                e.x = 8'(x);
                e.y = 8'(y);
                case (mode)
                    0:       e.d = data;
                    1:       e.d = 8'h00;
                    2:       e.d = (((x ^ y) & 1) != 0) ? ~data : data;
                    default: e.d = data + 8'(idx);
                endcase
                sb.push_back(e);
                idx++;
            end
        end
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input int mode, input logic [7:0] data);
        @(negedge clk);
        cmd_x0    = 8'(x0);
        cmd_y0    = 8'(y0);
        cmd_x1    = 8'(x1);
        cmd_y1    = 8'(y1);
        cmd_mode  = 2'(mode);
        cmd_data  = data;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done || err) seen = 1'b1;
        end
        check({tag, "_finished"}, {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int b_done, b_err, b_wr, b_busy;
        bit saw_we;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_x1    = '0;
        cmd_y1    = '0;
        cmd_mode  = '0;
        cmd_data  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {31'd0, fb_we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // 2x2 solid fill
        ack_delay = 1;
        b_done = n_done; b_wr = n_writes;
        push_rect(2, 1, 3, 2, 0, 8'hA5);
        send_cmd(2, 1, 3, 2, 0, 8'hA5);
        wait_end("solid", 100);
        check("solid_done_cnt", 32'(n_done - b_done), 32'd1);
        check("solid_writes", 32'(n_writes - b_wr), 32'd4);
        check("solid_sb_empty", 32'(sb.size()), 32'd0);
        check("solid_ready", {31'd0, cmd_ready}, 32'd1);
        check("solid_busy", {31'd0, busy}, 32'd0);

        // Swapped corners, ramp
        ack_delay = 0;
        b_done = n_done; b_wr = n_writes;
        push_rect(5, 0, 4, 0, 3, 8'hFE);
        send_cmd(5, 0, 4, 0, 3, 8'hFE);
        wait_end("ramp", 100);
        check("ramp_done_cnt", 32'(n_done - b_done), 32'd1);
        check("ramp_writes", 32'(n_writes - b_wr), 32'd2);
        check("ramp_sb_empty", 32'(sb.size()), 32'd0);

        // Checker 2x2 at origin
        b_done = n_done; b_wr = n_writes;
        push_rect(0, 0, 1, 1, 2, 8'h0F);
        send_cmd(0, 0, 1, 1, 2, 8'h0F);
        wait_end("checker", 100);
        check("checker_done_cnt", 32'(n_done - b_done), 32'd1);
        check("checker_writes", 32'(n_writes - b_wr), 32'd4);
        check("checker_sb_empty", 32'(sb.size()), 32'd0);

        // Clear mode, single cell
        b_done = n_done; b_wr = n_writes;
        push_rect(9, 9, 9, 9, 1, 8'hEE);
        send_cmd(9, 9, 9, 9, 1, 8'hEE);
        wait_end("clear", 60);
        check("clear_writes", 32'(n_writes - b_wr), 32'd1);
        check("clear_sb_empty", 32'(sb.size()), 32'd0);

        // Out-of-range corner
        b_done = n_done; b_wr = n_writes; b_err = n_err; b_busy = n_busy;
`ifdef FB_RECT_FILLER_CLIP_EN
        push_rect(126, 3, 200, 3, 0, 8'h3C);
        send_cmd(126, 3, 200, 3, 0, 8'h3C);
        wait_end("clip", 100);
        check("clip_err_cnt", 32'(n_err - b_err), 32'd0);
        check("clip_done_cnt", 32'(n_done - b_done), 32'd1);
        check("clip_writes", 32'(n_writes - b_wr), 32'd2);
        check("clip_sb_empty", 32'(sb.size()), 32'd0);
`else
        send_cmd(126, 3, 200, 3, 0, 8'h3C);
        wait_end("oob", 20);
        check("oob_err_cnt", 32'(n_err - b_err), 32'd1);
        check("oob_done_cnt", 32'(n_done - b_done), 32'd0);
        check("oob_writes", 32'(n_writes - b_wr), 32'd0);
        check("oob_busy_cycles", 32'(n_busy - b_busy), 32'd1);
        check("oob_ready", {31'd0, cmd_ready}, 32'd1);
`endif

        // Stalled ack with a competing command that must be ignored
        ack_delay = 10;
        b_done = n_done; b_wr = n_writes;
        push_rect(7, 7, 7, 7, 0, 8'h55);
        send_cmd(7, 7, 7, 7, 0, 8'h55);
        repeat (4) @(negedge clk);
        cmd_x0 = 8'd20; cmd_y0 = 8'd20; cmd_x1 = 8'd21; cmd_y1 = 8'd21;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("busy_ready_low", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_end("stall", 100);
        check("stall_done_cnt", 32'(n_done - b_done), 32'd1);
        check("stall_writes", 32'(n_writes - b_wr), 32'd1);
        repeat (10) @(negedge clk);
        check("ignored_cmd_writes", 32'(n_writes - b_wr), 32'd1);
        check("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while waiting for an ack mid-rectangle
        ack_delay = 5;
        b_done = n_done;
        push_rect(0, 5, 2, 5, 0, 8'h11);
        send_cmd(0, 5, 2, 5, 0, 8'h11);
        saw_we = 1'b0;
        for (int i = 0; i < 20 && !saw_we; i++) begin
            @(negedge clk);
            if (fb_we) saw_we = 1'b1;
        end
        check("midrst_saw_we", {31'd0, saw_we}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_we", {31'd0, fb_we}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
        repeat (10) @(negedge clk);
        check("midrst_no_done", 32'(n_done - b_done), 32'd0);
        check("midrst_we_idle", {31'd0, fb_we}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
